i2c_target_responder: RTL and testbench

I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

---
 rtl/i2c_target_responder.sv | 254 +++++++++++++++++++++++++
 tb/tb_i2c_target_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_responder.sv
// i2c_target_responder: I2C target with an internal bank of 8-bit registers.
//
// A write transaction loads the register pointer from the first data byte,
// then stores each later byte at the pointer and advances it. A read
// transaction returns bytes from the pointer onwards. The pointer wraps modulo
// NUM_REGS and is kept across a repeated START. SCL is never stretched.
//
// Ports:
//   clk        system clock; all state changes on its rising edge
//   s_reset    synchronous, active-high reset
//   i2c_scl    raw bus SCL (asynchronous to clk)
//   i2c_sda    raw bus SDA (asynchronous to clk)
//   sda_pull   1 = drive SDA low (open-drain enable), 0 = release
//   wr_strobe  one-cycle pulse when a data byte is written to a register
//   wr_ptr     register index of the current wr_strobe
//   wr_data    data byte of the current wr_strobe
//   busy       high from an addressed START until STOP or NACK on read
module i2c_target_responder #(
  parameter logic [6:0]   TARGET_ADDR = 7'h50,
  parameter int unsigned  NUM_REGS    = 16,
  localparam int unsigned PTR_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             s_reset,
  input  logic             i2c_scl,
  input  logic             i2c_sda,
  output logic             sda_pull,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StWrData, StWrAck, StRdData, StRdAck, StWaitStop
  } state_e;

  // Synchronizers (meta, sync) plus one history flop for edge detection.
  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [6:0]       shreg_q, shreg_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             nack_q, nack_d;
  // Set once the ninth (acknowledge) clock has risen in an ACK state.
  logic             ack_clk_q, ack_clk_d;
  logic             sda_pull_q, sda_pull_d;
  logic             busy_q, busy_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             reg_we;
  logic [7:0]       regs_q [NUM_REGS];

  logic       scl_rise, scl_fall, start_det, stop_det, rd_bit;
  logic [7:0] byte_d;

  assign scl_rise  = scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q & scl_hist_q;
  assign start_det = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
  assign byte_d    = {shreg_q, sda_sync_q};
  // Bit to present next; cnt_q is 0 in the ACK states, selecting the MSB.
  assign rd_bit    = regs_q[ptr_q][3'd7 - cnt_q];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    nack_d      = nack_q;
    ack_clk_d   = ack_clk_q;
    sda_pull_d  = sda_pull_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;

    if (stop_det) begin
      state_d    = StIdle;
      cnt_d      = '0;
      ack_clk_d  = 1'b0;
      sda_pull_d = 1'b0;
      busy_d     = 1'b0;
    end else if (start_det) begin
      // Any partial byte is dropped; the pointer survives a repeated START.
      state_d    = StAddr;
      cnt_d      = '0;
      ack_clk_d  = 1'b0;
      sda_pull_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: begin
        end
        StAddr: begin
          if (scl_rise) begin
            shreg_d = byte_d[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d      = sda_sync_q;
              ack_clk_d = 1'b0;
              if (byte_d[7:1] == TARGET_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
              end else begin
                state_d = StWaitStop;
                busy_d  = 1'b0;
              end
            end
          end
        end
        StPtr, StWrData: begin
          if (scl_rise) begin
            shreg_d = byte_d[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d   = StWrAck;
              ack_clk_d = 1'b0;
              if (state_q == StPtr) begin
                ptr_d = byte_d[PTR_W-1:0];
              end else begin
                reg_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_ptr_d    = ptr_q;
                wr_data_d   = byte_d;
                ptr_d       = ptr_q + PTR_W'(1);
              end
            end
          end
        end
        StAddrAck, StWrAck: begin
          if (scl_rise) begin
            ack_clk_d = 1'b1;
          end else if (scl_fall) begin
            if (!ack_clk_q) begin
              sda_pull_d = 1'b1;
            end else begin
              ack_clk_d  = 1'b0;
              cnt_d      = '0;
              sda_pull_d = 1'b0;
              if (state_q == StWrAck) begin
                state_d = StWrData;
              end else if (rw_q) begin
                state_d    = StRdData;
                sda_pull_d = ~rd_bit;
              end else begin
                state_d = StPtr;
              end
            end
          end
        end
        StRdData: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d   = StRdAck;
              ack_clk_d = 1'b0;
              ptr_d     = ptr_q + PTR_W'(1);
            end
          end else if (scl_fall) begin
            sda_pull_d = ~rd_bit;
          end
        end
        StRdAck: begin
          if (scl_rise) begin
            ack_clk_d = 1'b1;
            nack_d    = sda_sync_q;
          end else if (scl_fall) begin
            sda_pull_d = 1'b0;
            if (ack_clk_q) begin
              ack_clk_d = 1'b0;
              cnt_d     = '0;
              if (nack_q) begin
                state_d = StWaitStop;
                busy_d  = 1'b0;
              end else begin
                state_d    = StRdData;
                sda_pull_d = ~rd_bit;
              end
            end
          end
        end
        default: begin
          state_d    = StIdle;
          sda_pull_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (s_reset) begin
      scl_meta_q  <= 1'b1;
      scl_sync_q  <= 1'b1;
      scl_hist_q  <= 1'b1;
      sda_meta_q  <= 1'b1;
      sda_sync_q  <= 1'b1;
      sda_hist_q  <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
      ack_clk_q   <= 1'b0;
      sda_pull_q  <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_ptr_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      scl_meta_q  <= i2c_scl;
      scl_sync_q  <= scl_meta_q;
      scl_hist_q  <= scl_sync_q;
      sda_meta_q  <= i2c_sda;
      sda_sync_q  <= sda_meta_q;
      sda_hist_q  <= sda_sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      nack_q      <= nack_d;
      ack_clk_q   <= ack_clk_d;
      sda_pull_q  <= sda_pull_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (s_reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (reg_we) begin
      regs_q[ptr_q] <= byte_d;
    end
  end

  assign sda_pull  = sda_pull_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_ptr    = wr_ptr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: a bit-banged I2C controller drives the bus
// (wired-AND with the target's sda_pull) and results are compared against a
// register-array/pointer model of the target.
module tb_i2c_target_responder;

  localparam int Q = 6;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       s_reset = 1'b1;
  logic       scl_ctl = 1'b1;
  logic       sda_ctl = 1'b1;
  logic       sda_bus;
  logic       sda_pull, wr_strobe, busy;
  logic [3:0] wr_ptr;
  logic [7:0] wr_data;

  assign sda_bus = sda_ctl & ~sda_pull;

  i2c_target_responder dut (
    .clk      (clk),
    .s_reset  (s_reset),
    .i2c_scl  (scl_ctl),
    .i2c_sda  (sda_bus),
    .sda_pull (sda_pull),
    .wr_strobe(wr_strobe),
    .wr_ptr   (wr_ptr),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_regs [16];
  int         model_ptr = 0;
  logic [7:0] wdata [8];

  // Output monitor, sampled on the falling clk edge.
  logic [11:0] strobe_log [$];
  int          pull_cnt = 0;
  int          busy_cnt = 0;
  int          pull_hi_chg = 0;
  logic        pull_prev = 1'b0;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_log.push_back({wr_ptr, wr_data});
    if (sda_pull === 1'b1) pull_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (scl_ctl && !$isunknown(sda_pull) && sda_pull !== pull_prev) pull_hi_chg++;
    pull_prev = sda_pull;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    sda_ctl = 1'b1; wait_clk(Q);
    scl_ctl = 1'b1; wait_clk(Q);
    sda_ctl = 1'b0; wait_clk(Q);
    scl_ctl = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_ctl = 1'b0; wait_clk(Q);
    scl_ctl = 1'b1; wait_clk(Q);
    sda_ctl = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic send_bit(input logic b, output logic s);
    wait_clk(Q);
    sda_ctl = b;
    wait_clk(Q);
    scl_ctl = 1'b1;
    wait_clk(Q);
    s = sda_bus;
    wait_clk(Q);
    scl_ctl = 1'b0;
  endtask

  task automatic tx_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rx_byte(input logic ack_bit, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(ack_bit, s);
  endtask

  task automatic write_txn(input logic [7:0] p, input int n);
    logic a;
    int   base;
    int   idx;
    base = strobe_log.size();
    bus_start();
    tx_byte(8'hA0, a);
    check("wr_addr_ack", 32'(a), 32'd1);
    check("busy_addressed", 32'(busy), 32'd1);
    tx_byte(p, a);
    check("wr_ptr_ack", 32'(a), 32'd1);
    for (int i = 0; i < n; i++) begin
      tx_byte(wdata[i], a);
      check("wr_data_ack", 32'(a), 32'd1);
    end
    bus_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
    check("strobe_count", 32'(strobe_log.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < strobe_log.size(); i++) begin
      idx = (int'(p) + i) % 16;
      check("strobe_ptr_data", 32'(strobe_log[base + i]), 32'({4'(idx), wdata[i]}));
    end
    for (int i = 0; i < n; i++) model_regs[(int'(p) + i) % 16] = wdata[i];
    model_ptr = (int'(p) + n) % 16;
  endtask

  // Sets the pointer, then reads n bytes through a repeated START.
  task automatic read_txn(input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] b;
    int         base;
    base = strobe_log.size();
    bus_start();
    tx_byte(8'hA0, a);
    check("rd_addr_w_ack", 32'(a), 32'd1);
    tx_byte(p, a);
    check("rd_ptr_ack", 32'(a), 32'd1);
    bus_start();
    tx_byte(8'hA1, a);
    check("rd_addr_r_ack", 32'(a), 32'd1);
    for (int i = 0; i < n; i++) begin
      rx_byte(i == n - 1, b);
      check("rd_data", 32'(b), 32'(model_regs[(int'(p) + i) % 16]));
    end
    wait_clk(4);
    check("busy_after_nack", 32'(busy), 32'd0);
    bus_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
    check("rd_no_strobe", 32'(strobe_log.size() - base), 32'd0);
    model_ptr = (int'(p) + n) % 16;
  endtask

  initial begin
    logic       a, s;
    logic [7:0] b;
    int         base, pc, bc;
    int         n;
    logic [7:0] p;

    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    wait_clk(4);
    s_reset = 1'b0;
    wait_clk(2);
    check("reset_sda_pull", 32'(sda_pull), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_wr_strobe", 32'(wr_strobe), 32'd0);
    check("reset_wr_ptr", 32'(wr_ptr), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);

    // Basic write then read back through a repeated START.
    wdata[0] = 8'h5A; wdata[1] = 8'hC3;
    write_txn(8'h03, 2);
    read_txn(8'h03, 2);

    // Pointer wrap.
    wdata[0] = 8'h11; wdata[1] = 8'h22;
    write_txn(8'h0F, 2);
    read_txn(8'h0F, 2);

    // Address mismatch: no ACK, no drive, no busy, no strobe.
    base = strobe_log.size(); pc = pull_cnt; bc = busy_cnt;
    bus_start();
    tx_byte(8'hA2, a);
    check("mismatch_addr_ack", 32'(a), 32'd0);
    tx_byte(8'h00, a);
    check("mismatch_data_ack", 32'(a), 32'd0);
    bus_stop();
    check("mismatch_pull", 32'(pull_cnt - pc), 32'd0);
    check("mismatch_busy", 32'(busy_cnt - bc), 32'd0);
    check("mismatch_strobe", 32'(strobe_log.size() - base), 32'd0);

    // STOP after four data bits aborts the byte.
    base = strobe_log.size();
    bus_start();
    tx_byte(8'hA0, a);
    check("abort_addr_ack", 32'(a), 32'd1);
    tx_byte(8'h05, a);
    check("abort_ptr_ack", 32'(a), 32'd1);
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b1, s);
    bus_stop();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_strobe", 32'(strobe_log.size() - base), 32'd0);
    model_ptr = 5;
    read_txn(8'h05, 1);

    // Reset while the target drives a 0 bit.
    wdata[0] = 8'h0F;
    write_txn(8'h07, 1);
    bus_start();
    tx_byte(8'hA0, a);
    tx_byte(8'h07, a);
    bus_start();
    tx_byte(8'hA1, a);
    check("rst_rd_addr_ack", 32'(a), 32'd1);
    wait_clk(4);
    check("rst_rd_drive_zero", 32'(sda_pull), 32'd1);
    s_reset = 1'b1;
    wait_clk(1);
    s_reset = 1'b0;
    check("rst_release_next", 32'(sda_pull), 32'd0);
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    model_ptr = 0;
    pc = pull_cnt;
    for (int i = 0; i < 8; i++) send_bit(1'b1, s);
    check("rst_ignore_rest", 32'(pull_cnt - pc), 32'd0);
    bus_start();
    tx_byte(8'hA1, a);
    check("rst_new_addr_ack", 32'(a), 32'd1);
    rx_byte(1'b1, b);
    check("rst_new_read", 32'(b), 32'(model_regs[model_ptr]));
    bus_stop();
    model_ptr = (model_ptr + 1) % 16;
    read_txn(8'h00, 16);

    // Randomized write/read-back pairs.
    for (int k = 0; k < 6; k++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
      write_txn(p, n);
      read_txn(8'($urandom_range(0, 15)), $urandom_range(1, 3));
    end

    check("pull_change_scl_high", 32'(pull_hi_chg), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
